// File: rtl/mem_drain_ctrl.sv
// Read-side drain controller for the 2-entry tagged word buffer: tracks occupancy from the
// producer's write strobe, issues reads, and re-times the 1-cycle read latency through a skid queue.
module mem_drain_ctrl #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned EXTRA_BITS    = 2,
    parameter int unsigned ADDRESS_WIDTH = 1,
    parameter int unsigned RAM_DEPTH     = 1 << ADDRESS_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             mem_wr_en,
    output logic                             mem_rd_en,
    input  logic [DATA_WIDTH+EXTRA_BITS-1:0] mem_data,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [DATA_WIDTH-1:0]            m_data,
    output logic [EXTRA_BITS-1:0]            m_tag,
    output logic [ADDRESS_WIDTH:0]           level,
    output logic                             overflow,
    output logic [15:0]                      words_out
);

    localparam int unsigned WORD_WIDTH  = DATA_WIDTH + EXTRA_BITS;
    localparam int unsigned LEVEL_WIDTH = ADDRESS_WIDTH + 1;
    localparam logic [ADDRESS_WIDTH:0] FULL_LEVEL = LEVEL_WIDTH'(RAM_DEPTH);

    logic [WORD_WIDTH-1:0] skid [2];
    logic                  skid_head;
    logic                  skid_tail;
    logic [1:0]            skid_cnt;
    logic                  inflight;
    logic                  pop;
    logic                  full_write;
    logic                  wr_accept;
    logic [WORD_WIDTH-1:0] head_word;

    // Free space ignores a same-cycle pop so the read strobe depends on registered state only.
    assign mem_rd_en  = (level != '0) && ((skid_cnt + {1'b0, inflight}) < 2'd2);
    assign m_valid    = (skid_cnt != 2'd0);
    assign pop        = m_valid && m_ready;
    assign full_write = mem_wr_en && (level == FULL_LEVEL) && !mem_rd_en;
    assign wr_accept  = mem_wr_en && !full_write;
    assign head_word  = skid[skid_head];
    assign m_data     = head_word[DATA_WIDTH-1:0];
    assign m_tag      = head_word[WORD_WIDTH-1:DATA_WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level     <= '0;
            overflow  <= 1'b0;
            inflight  <= 1'b0;
            skid[0]   <= '0;
            skid[1]   <= '0;
            skid_head <= 1'b0;
            skid_tail <= 1'b0;
            skid_cnt  <= 2'd0;
            words_out <= '0;
        end else begin
            case ({wr_accept, mem_rd_en})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (full_write) begin
                overflow <= 1'b1;
            end
            inflight <= mem_rd_en;
            if (inflight) begin
                skid[skid_tail] <= mem_data;
                skid_tail       <= ~skid_tail;
            end
            if (pop) begin
                skid_head <= ~skid_head;
                words_out <= words_out + 16'd1;
            end
            case ({inflight, pop})
                2'b10:   skid_cnt <= skid_cnt + 2'd1;
                2'b01:   skid_cnt <= skid_cnt - 2'd1;
                default: skid_cnt <= skid_cnt;
            endcase
        end
    end

    skid_no_overflow: assert property (@(posedge clk) disable iff (rst)
        inflight |-> (skid_cnt != 2'd2 || pop));

    level_bounded: assert property (@(posedge clk) disable iff (rst)
        level <= FULL_LEVEL);

endmodule
